// File: rtl/serial_priority_encoder_pkg.sv
// Shared definitions for the serial priority encoder: state encoding and
// elaboration-time helpers.
package serial_priority_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) c += int'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/serial_priority_encoder_prio_find.sv
// Combinational priority search over a request vector: winning index,
// any-bit-set flag and at-most-one-bit-set flag.
module prio_find
    import serial_priority_encoder_pkg::*;
#(
    parameter int N          = 8,
    parameter int HIGH_FIRST = 1,
    localparam int W         = clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         single
);

    assign any    = |vec;
    // Clearing the lowest set bit leaves zero only for one-hot or all-zero input.
    assign single = ((vec & (vec - N'(1))) == '0);

    always_comb begin
        idx = '0;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/serial_priority_encoder.sv
// Captures a request vector and emits the index of each set bit, one per
// output handshake, in priority order.
module serial_priority_encoder
    import serial_priority_encoder_pkg::*;
#(
    parameter int N          = 8,
    parameter int HIGH_FIRST = 1,
    localparam int W         = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none,
    output logic [W:0]   out_cnt,
    output state_t       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never depends on ready, and a producer holding valid=1 keeps
    // its payload stable until that transfer.

    state_t         state, state_next;
    logic [N-1:0]   pending, pending_next;
    logic [W:0]     cnt_q, cnt_next;
    logic [W-1:0]   find_idx;
    logic           find_any;
    logic           find_single;
    logic           busy;

    prio_find #(
        .N          (N),
        .HIGH_FIRST (HIGH_FIRST)
    ) u_find (
        .vec    (pending),
        .idx    (find_idx),
        .any    (find_any),
        .single (find_single)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            cnt_q   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending;
        cnt_next     = cnt_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pending_next = in_req;
                    cnt_next     = (W + 1)'(popcount(64'(in_req)));
                    state_next   = BUSY;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    if (find_single) begin
                        pending_next = '0;
                        cnt_next     = '0;
                        state_next   = IDLE;
                    end else begin
                        pending_next = pending & ~(N'(1) << find_idx);
                    end
                end
            end
            default: begin
                pending_next = '0;
                cnt_next     = '0;
                state_next   = IDLE;
            end
        endcase
    end

    // Pending is only all-zero while BUSY when the captured vector was zero.
    assign busy      = (state == BUSY);
    assign in_ready  = !busy;
    assign out_valid = busy;
    assign out_idx   = busy ? find_idx : '0;
    assign out_last  = busy & find_single;
    assign out_none  = busy & ~find_any;
    assign out_cnt   = cnt_q;
    assign dbg_state = state;

endmodule
